// File: rtl/mmio_input_port_pkg.sv
// Shared definitions for the MMIO debounced input port: register offsets,
// window size and the per-channel edge-select encoding.
package mmio_input_port_pkg;

  localparam int unsigned BUS_W    = 32;
  localparam int unsigned WIN_SIZE = 16;

  localparam logic [3:0] OFF_STATE = 4'h0;
  localparam logic [3:0] OFF_PEND  = 4'h4;
  localparam logic [3:0] OFF_MASK  = 4'h8;
  localparam logic [3:0] OFF_EDGE  = 4'hC;

  typedef enum logic {
    RISE = 1'b0,
    FALL = 1'b1
  } edge_sel_t;

  // True when the prev->cur transition of a stable value matches the selected edge.
  function automatic logic edge_match(input edge_sel_t sel, input logic prev, input logic cur);
    return (sel == RISE) ? (cur & ~prev) : (~cur & prev);
  endfunction

endpackage

// File: rtl/mmio_input_port_input_debouncer.sv
// One channel: 2-flop synchronizer, saturating-free debounce counter and the
// accepted (stable) value.
module input_debouncer #(
  parameter int unsigned DB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam int unsigned        CNT_W    = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             synced;

  assign synced = sync_q[1];

  // Bring the asynchronous input into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  // Count cycles of disagreement; accept the new level once it has persisted
  // DB_CYCLES cycles. The counter clears on the toggle so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      stable <= 1'b0;
    end else if (synced == stable) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q  <= '0;
      stable <= ~stable;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mmio_input_port.sv
// Memory-mapped debounced input port with STATE/PEND/MASK/EDGE registers and
// a level interrupt that follows the OR of pending events.
module mmio_input_port
  import mmio_input_port_pkg::*;
#(
  parameter int unsigned       NUM_CH    = 5,
  parameter int unsigned       DB_CYCLES = 250000,
  parameter logic [BUS_W-1:0]  BASE_ADDR = 32'h110B0000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NUM_CH-1:0] BTN_IN,
  input  logic [BUS_W-1:0]  IOBUS_ADDR,
  input  logic [BUS_W-1:0]  IOBUS_OUT,
  input  logic              IOBUS_WR,
  output logic [BUS_W-1:0]  RD_DATA,
  output logic              RD_HIT,
  output logic              INTR
);

  logic [NUM_CH-1:0] state_q;
  logic [NUM_CH-1:0] state_prev_q;
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] edge_q;
  logic [NUM_CH-1:0] event_c;
  logic [NUM_CH-1:0] wdata;
  logic [NUM_CH-1:0] pend_clr;
  logic              sel_state, sel_pend, sel_mask, sel_edge;

  assign wdata = IOBUS_OUT[NUM_CH-1:0];

  // Upper write-data bits have no storage behind them.
  if (NUM_CH < BUS_W) begin : g_unused_wdata
    logic unused_hi;
    assign unused_hi = ^IOBUS_OUT[BUS_W-1:NUM_CH];
  end

  // Per-channel debouncer and edge-qualified event detect.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    input_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk    (CLK),
      .rst_n  (RST_N),
      .raw    (BTN_IN[i]),
      .stable (state_q[i])
    );
    assign event_c[i] = edge_match(edge_sel_t'(edge_q[i]), state_prev_q[i], state_q[i]);
  end

  // Exact-match address decode for the four registers.
  always_comb begin
    sel_state = (IOBUS_ADDR == BASE_ADDR + BUS_W'(OFF_STATE));
    sel_pend  = (IOBUS_ADDR == BASE_ADDR + BUS_W'(OFF_PEND));
    sel_mask  = (IOBUS_ADDR == BASE_ADDR + BUS_W'(OFF_MASK));
    sel_edge  = (IOBUS_ADDR == BASE_ADDR + BUS_W'(OFF_EDGE));
    pend_clr  = (IOBUS_WR && sel_pend) ? wdata : '0;
  end

  // Combinational read mux; zero on a miss.
  always_comb begin
    RD_DATA = '0;
    RD_HIT  = sel_state | sel_pend | sel_mask | sel_edge;
    if (sel_state)     RD_DATA = BUS_W'(state_q);
    else if (sel_pend) RD_DATA = BUS_W'(pend_q);
    else if (sel_mask) RD_DATA = BUS_W'(mask_q);
    else if (sel_edge) RD_DATA = BUS_W'(edge_q);
  end

  // Register file, pending events (set beats clear) and registered interrupt.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_prev_q <= '0;
      pend_q       <= '0;
      mask_q       <= '0;
      edge_q       <= '0;
      INTR         <= 1'b0;
    end else begin
      state_prev_q <= state_q;
      pend_q       <= (pend_q & ~pend_clr) | (event_c & mask_q);
      INTR         <= |pend_q;
      if (IOBUS_WR && sel_mask) mask_q <= wdata;
      if (IOBUS_WR && sel_edge) edge_q <= wdata;
    end
  end

endmodule

// File: tb/tb_mmio_input_port.sv
// Randomized, self-checking bench for mmio_input_port against a
// cycle-level behavioural model of the register window.
module tb_mmio_input_port;
  import mmio_input_port_pkg::*;

  localparam int unsigned NCH  = 5;
  localparam int unsigned DB   = 4;
  localparam logic [31:0] BASE = 32'h110B0000;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [NCH-1:0]  BTN_IN = '0;
  logic [31:0]     IOBUS_ADDR = '0;
  logic [31:0]     IOBUS_OUT = '0;
  logic            IOBUS_WR = 1'b0;
  logic [31:0]     RD_DATA;
  logic            RD_HIT;
  logic            INTR;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  mmio_input_port #(.NUM_CH(NCH), .DB_CYCLES(DB), .BASE_ADDR(BASE)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .BTN_IN     (BTN_IN),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .RD_DATA    (RD_DATA),
    .RD_HIT     (RD_HIT),
    .INTR       (INTR)
  );

  // Model: raw samples per clock edge (newest first); a level is accepted once
  // the synchronized input has disagreed with it for DB consecutive cycles.
  logic [NCH-1:0] m_hist [DB+2];
  logic [NCH-1:0] m_state, m_prev, m_pend, m_mask, m_edge;
  logic           m_intr;

  function automatic void model_reset();
    for (int i = 0; i < DB + 2; i++) m_hist[i] = '0;
    m_state = '0; m_prev = '0; m_pend = '0; m_mask = '0; m_edge = '0; m_intr = 1'b0;
  endfunction

  function automatic void model_edge();
    logic [NCH-1:0] ev, clr, wd, nxt;
    logic           all_diff;
    wd  = IOBUS_OUT[NCH-1:0];
    ev  = (m_state & ~m_prev & ~m_edge) | (~m_state & m_prev & m_edge);
    clr = (IOBUS_WR && IOBUS_ADDR == BASE + 32'(OFF_PEND)) ? wd : '0;
    m_intr = |m_pend;
    m_pend = (m_pend & ~clr) | (ev & m_mask);
    if (IOBUS_WR && IOBUS_ADDR == BASE + 32'(OFF_MASK)) m_mask = wd;
    if (IOBUS_WR && IOBUS_ADDR == BASE + 32'(OFF_EDGE)) m_edge = wd;
    for (int i = DB + 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = BTN_IN;
    nxt = m_state;
    for (int ch = 0; ch < NCH; ch++) begin
      all_diff = 1'b1;
      for (int j = 2; j < DB + 2; j++)
        if (m_hist[j][ch] == m_state[ch]) all_diff = 1'b0;
      if (all_diff) nxt[ch] = ~m_state[ch];
    end
    m_prev  = m_state;
    m_state = nxt;
  endfunction

  task automatic step();
    @(posedge CLK);
    if (!RST_N) model_reset();
    else        model_edge();
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a; IOBUS_OUT = d; IOBUS_WR = 1'b1;
    step();
    IOBUS_WR = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
    IOBUS_ADDR = a;
    #1;
    d = RD_DATA; h = RD_HIT;
  endtask

  task automatic do_reset();
    RST_N = 1'b0; BTN_IN = '0; IOBUS_WR = 1'b0;
    model_reset();
    step(); step();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic h;
    model_reset();
    #1;
    for (int k = 0; k < 4; k++) begin
      bus_read(BASE + 32'(k * 4), d, h);
      n_vec++;
      if (d !== 32'h0 || h !== 1'b1) begin
        n_err++; $display("FAIL reset_reg%0d got data=%h hit=%b exp data=0 hit=1", k, d, h);
      end
    end
    n_vec++;
    if (INTR !== 1'b0) begin n_err++; $display("FAIL reset_intr got %b exp 0", INTR); end
    step(); step();
    RST_N = 1'b1;
  endtask

  task automatic test_press();
    logic [31:0] d; logic h;
    do_reset();
    bus_write(BASE + 32'(OFF_MASK), 32'h1);
    BTN_IN = 5'b00001;
    for (int c = 1; c <= 9; c++) begin
      step();
      bus_read(BASE + 32'(OFF_STATE), d, h);
      n_vec++;
      if (d !== ((c >= 6) ? 32'h1 : 32'h0)) begin
        n_err++; $display("FAIL press_state cyc%0d got %h exp %h", c, d, (c >= 6) ? 1 : 0);
      end
      bus_read(BASE + 32'(OFF_PEND), d, h);
      n_vec++;
      if (d !== ((c >= 7) ? 32'h1 : 32'h0)) begin
        n_err++; $display("FAIL press_pend cyc%0d got %h exp %h", c, d, (c >= 7) ? 1 : 0);
      end
      n_vec++;
      if (INTR !== ((c >= 8) ? 1'b1 : 1'b0)) begin
        n_err++; $display("FAIL press_intr cyc%0d got %b exp %b", c, INTR, c >= 8);
      end
    end
  endtask

  task automatic test_glitch();
    logic [31:0] ds, dp; logic h;
    do_reset();
    bus_write(BASE + 32'(OFF_MASK), 32'h1F);
    BTN_IN[2] = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (c == 3) BTN_IN[2] = 1'b0;
      step();
      bus_read(BASE + 32'(OFF_STATE), ds, h);
      bus_read(BASE + 32'(OFF_PEND), dp, h);
      n_vec++;
      if (ds !== 32'h0 || dp !== 32'h0 || INTR !== 1'b0) begin
        n_err++; $display("FAIL glitch cyc%0d got state=%h pend=%h intr=%b exp all 0", c, ds, dp, INTR);
      end
    end
  endtask

  task automatic test_fall_edge();
    logic [31:0] d; logic h;
    do_reset();
    bus_write(BASE + 32'(OFF_EDGE), 32'h2);
    bus_write(BASE + 32'(OFF_MASK), 32'h2);
    BTN_IN[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      bus_read(BASE + 32'(OFF_PEND), d, h);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("FAIL fall_press_pend cyc%0d got %h exp 0", c, d); end
    end
    bus_read(BASE + 32'(OFF_STATE), d, h);
    n_vec++;
    if (d !== 32'h2) begin n_err++; $display("FAIL fall_state got %h exp 2", d); end
    BTN_IN[1] = 1'b0;
    for (int c = 0; c < 9; c++) begin
      step();
      bus_read(BASE + 32'(OFF_PEND), d, h);
      n_vec++;
      if (d !== 32'(m_pend)) begin n_err++; $display("FAIL fall_rel_pend cyc%0d got %h exp %h", c, d, m_pend); end
    end
    bus_read(BASE + 32'(OFF_PEND), d, h);
    n_vec++;
    if (d !== 32'h2 || INTR !== 1'b1) begin
      n_err++; $display("FAIL fall_pend_set got pend=%h intr=%b exp pend=2 intr=1", d, INTR);
    end
    bus_write(BASE + 32'(OFF_PEND), 32'h2);
    bus_read(BASE + 32'(OFF_PEND), d, h);
    n_vec++;
    if (d !== 32'h0) begin n_err++; $display("FAIL fall_pend_clr got %h exp 0", d); end
    step();
    n_vec++;
    if (INTR !== 1'b0) begin n_err++; $display("FAIL fall_intr_clr got %b exp 0", INTR); end
  endtask

  task automatic test_set_wins();
    logic [31:0] d; logic h;
    do_reset();
    bus_write(BASE + 32'(OFF_MASK), 32'h1);
    BTN_IN[0] = 1'b1;
    repeat (8) step();
    BTN_IN[0] = 1'b0;
    repeat (8) step();
    BTN_IN[0] = 1'b1;
    repeat (6) step();
    bus_write(BASE + 32'(OFF_PEND), 32'h1);
    bus_read(BASE + 32'(OFF_PEND), d, h);
    n_vec++;
    if (d !== 32'h1) begin n_err++; $display("FAIL setwins_pend got %h exp 1", d); end
    step();
    n_vec++;
    if (INTR !== 1'b1) begin n_err++; $display("FAIL setwins_intr got %b exp 1", INTR); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic h;
    do_reset();
    bus_write(BASE + 32'(OFF_MASK), 32'h1F);
    bus_write(BASE + 32'(OFF_EDGE), 32'h0);
    BTN_IN = 5'b10101;
    repeat (8) step();
    bus_read(BASE + 32'(OFF_PEND), d, h);
    n_vec++;
    if (d !== 32'h15) begin n_err++; $display("FAIL rstmid_pre_pend got %h exp 15", d); end
    BTN_IN = 5'b10111;
    repeat (3) step();
    #1;
    RST_N = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      bus_read(BASE + 32'(k * 4), d, h);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("FAIL rstmid_reg%0d got %h exp 0", k, d); end
    end
    n_vec++;
    if (INTR !== 1'b0) begin n_err++; $display("FAIL rstmid_intr got %b exp 0", INTR); end
    step(); step();
    RST_N = 1'b1;
    bus_write(BASE + 32'(OFF_MASK), 32'hFFFFFFFF);
    bus_read(BASE + 32'(OFF_MASK), d, h);
    n_vec++;
    if (d !== 32'h1F) begin n_err++; $display("FAIL rstmid_mask got %h exp 1f", d); end
    for (int c = 0; c < 8; c++) begin
      step();
      bus_read(BASE + 32'(OFF_STATE), d, h);
      n_vec++;
      if (d !== 32'(m_state)) begin n_err++; $display("FAIL rstmid_state cyc%0d got %h exp %h", c, d, m_state); end
    end
    bus_read(BASE + 32'(OFF_PEND), d, h);
    n_vec++;
    if (d !== 32'h17) begin n_err++; $display("FAIL rstmid_post_pend got %h exp 17", d); end
  endtask

  task automatic test_window();
    logic [31:0] d; logic h;
    logic [31:0] miss [3];
    miss[0] = BASE + 32'h10; miss[1] = BASE + 32'h2; miss[2] = BASE - 32'h4;
    for (int k = 0; k < 3; k++) begin
      bus_read(miss[k], d, h);
      n_vec++;
      if (d !== 32'h0 || h !== 1'b0) begin
        n_err++; $display("FAIL window_miss%0d got data=%h hit=%b exp data=0 hit=0", k, d, h);
      end
    end
    bus_write(BASE + 32'(OFF_STATE), 32'h0);
    bus_read(BASE + 32'(OFF_STATE), d, h);
    n_vec++;
    if (d !== 32'h17) begin n_err++; $display("FAIL window_state_wr got %h exp 17", d); end
    bus_write(BASE + 32'h10, 32'h0);
    bus_read(BASE + 32'(OFF_MASK), d, h);
    n_vec++;
    if (d !== 32'h1F) begin n_err++; $display("FAIL window_outside_wr got %h exp 1f", d); end
  endtask

  task automatic test_random();
    logic [31:0] d, a; logic h;
    logic [31:0] exp_v [4];
    int unsigned sel;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int ch = 0; ch < NCH; ch++)
        if ($urandom_range(0, 5) == 0) BTN_IN[ch] = ~BTN_IN[ch];
      if ($urandom_range(0, 4) == 0) begin
        sel = $urandom_range(0, 4);
        a = BASE + 32'(sel * 4);
        bus_write(a, $urandom());
      end else begin
        step();
      end
      exp_v[0] = 32'(m_state); exp_v[1] = 32'(m_pend);
      exp_v[2] = 32'(m_mask);  exp_v[3] = 32'(m_edge);
      for (int k = 0; k < 4; k++) begin
        bus_read(BASE + 32'(k * 4), d, h);
        n_vec++;
        if (d !== exp_v[k] || h !== 1'b1) begin
          n_err++; $display("FAIL random_reg%0d cyc%0d got data=%h hit=%b exp data=%h hit=1", k, c, d, h, exp_v[k]);
        end
      end
      n_vec++;
      if (INTR !== m_intr) begin n_err++; $display("FAIL random_intr cyc%0d got %b exp %b", c, INTR, m_intr); end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_fall_edge();
    test_set_wins();
    test_reset_mid();
    test_window();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_input_port.md
MMIO_INPUT_PORT -- requirements
Module: mmio_input_port

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, meaning number of input channels (legal range 1..32).
REQ-002 SHALL have parameter DB_CYCLES, default 250000, meaning consecutive clock cycles of stable input needed to accept a change (at least 2).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h110B0000, meaning base of the 16-byte register window.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock for all logic.
REQ-005 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port BTN_IN, input, NUM_CH bits: raw asynchronous button or switch inputs.
REQ-007 SHALL have port IOBUS_ADDR, input, 32 bits: CPU bus address.
REQ-008 SHALL have port IOBUS_OUT, input, 32 bits: CPU write data.
REQ-009 SHALL have port IOBUS_WR, input, 1 bit: CPU write strobe, one cycle per write.
REQ-010 SHALL have port RD_DATA, output, 32 bits: read data; drives zero when the address does not hit.
REQ-011 SHALL have port RD_HIT, output, 1 bit: IOBUS_ADDR matches one of the four registers.
REQ-012 SHALL have port INTR, output, 1 bit: level interrupt request to the MCU.

Function
REQ-013 Each BTN_IN bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Per-channel debounce: a counter SHALL increment while the synced input differs from the stable value, and SHALL clear to 0 whenever they are equal.
REQ-015 The stable value SHALL toggle on the cycle the counter reaches DB_CYCLES-1; the counter SHALL clear on that same cycle.
REQ-016 The counter SHALL NOT wrap, and a glitch shorter than DB_CYCLES cycles SHALL leave the stable value unchanged.
REQ-017 Register map, at offsets from BASE_ADDR:
 - +0x0 STATE (RO): stable values.
 - +0x4 PEND (RW1C): pending events.
 - +0x8 MASK (RW): event enable.
 - +0xC EDGE (RW): per bit, 0 = rising edge, 1 = falling edge.
REQ-018 Only bits [NUM_CH-1:0] SHALL be implemented; upper bits SHALL read 0 and SHALL ignore writes.
REQ-019 An event SHALL exist on the cycle after a stable-value change whose direction matches the channel's EDGE bit; it SHALL set PEND only if the MASK bit is 1.
REQ-020 A PEND write SHALL clear the bits written as 1; if a set event and a clear hit the same bit in the same cycle, the set SHALL win.
REQ-021 Writes to STATE, and writes to addresses outside the window, SHALL be ignored.
REQ-022 INTR SHALL be registered and equal the OR of all PEND bits, one cycle after PEND updates.
REQ-023 RD_DATA and RD_HIT SHALL be combinational from IOBUS_ADDR and the register contents.
REQ-024 Clearing a MASK bit SHALL NOT clear an already-set PEND bit.
REQ-025 Latency from a BTN_IN change to STATE: 2 synchronizer cycles plus DB_CYCLES cycles; PEND sets 1 cycle after STATE changes, and INTR rises 1 cycle after PEND.

Reset
REQ-026 While RST_N = 0, all of the following SHALL be 0 immediately and asynchronously: synchronizers, counters, STATE, PEND, MASK, EDGE, INTR.
REQ-027 A reset mid-debounce SHALL abandon the count; after reset release, inputs held high SHALL produce a rising event once the full debounce period has elapsed.

Structure
REQ-028 A shared package SHALL hold the four register offsets, the window size of 16, and an edge_sel_t enum (RISE, FALL).
REQ-029 The synchronizer, counter and stable flop SHALL form one sub-module, input_debouncer, instantiated NUM_CH times by a generate loop.

Verification
All scenarios use DB_CYCLES = 4, NUM_CH = 5, BASE_ADDR = 32'h110B0000.
REQ-030 Hold BTN_IN[0] = 1 from cycle 0 -> STATE reads 5'b00001 from cycle 6; with MASK = 1, PEND[0] = 1 at cycle 7 and INTR = 1 at cycle 8.
REQ-031 A 3-cycle pulse on BTN_IN[2] -> STATE, PEND and INTR stay 0.
REQ-032 EDGE[1] = 1 and MASK[1] = 1; press then release BTN_IN[1] -> PEND[1] sets only on the release; write 32'h2 to +0x4 -> PEND = 0 and INTR = 0 one cycle later.
REQ-033 A PEND clear in the same cycle as a new event on the same bit -> PEND stays 1 and INTR stays 1.
REQ-034 Pull RST_N low mid-count with PEND = 5'b10101 -> all registers read 0 immediately; write 32'hFFFFFFFF to MASK -> reads back 32'h0000001F.
REQ-035 Read BASE_ADDR + 0x10 -> RD_HIT = 0 and RD_DATA = 0; write to STATE -> no change.
